pwm_fade_ctrl: RTL and testbench
================================

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 Parameter: R, default 10, duty resolution; duty range 0..2^R, where 2^R means 100 %.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  one-cycle request to begin a fade; sampled only in IDLE.
REQ-005 Port: stop  input  1  abort request; priority over start in every state.
REQ-006 Port: breathe  input  1  mode select latched at start: 0 = single fade, 1 = continuous lo/hi oscillation.
REQ-007 Port: lo_duty  input  R+1  lower breathe bound, latched at start.
REQ-008 Port: hi_duty  input  R+1  single-fade target / upper breathe bound, latched at start.
REQ-009 Port: step  input  R+1  duty increment per step, latched at start.
REQ-010 Port: step_period  input  32  cycles between steps minus one, latched at start.
REQ-011 Port: duty  output  R+1  registered duty word driven to the PWM generator.
REQ-012 Port: busy  output  1  high while state is UP or DOWN.
REQ-013 Port: done  output  1  one-cycle pulse on completion of a single fade.

Function
REQ-014 The FSM SHALL have states IDLE, UP and DOWN; busy = (state != IDLE).
REQ-015 In IDLE with start=1 and stop=0, the block SHALL latch all inputs, clear the step timer to 0, and select a state by comparing the current duty with the latched target.
REQ-016 Latched lo_duty and hi_duty values above 2^R SHALL be clamped to 2^R; a latched step of 0 SHALL be treated as 1.
REQ-017 Single mode: the target is hi_duty. Go to UP if duty < target, DOWN if duty > target; if duty == target, stay in IDLE and pulse done on the next cycle.
REQ-018 Breathe mode with lo_duty < hi_duty: go to UP if duty < hi_duty, otherwise DOWN. Breathe mode with lo_duty >= hi_duty SHALL behave exactly as single mode.
REQ-019 Step timer: it increments every busy cycle. When timer == step_period, a step occurs and the timer returns to 0. Steps therefore occur every step_period+1 cycles, and the first duty change occurs step_period+1 cycles after start is sampled.
REQ-020 UP step: duty <= min(duty + step, upper target), computed in R+2 bits with no wrap-around.
REQ-021 DOWN step: duty <= max(duty - step, lower target), with no underflow. The lower target is lo_duty in breathe mode and hi_duty in single mode.
REQ-022 Single mode: on the step that makes duty equal the target, the FSM SHALL enter IDLE and done SHALL assert for exactly one cycle. In that cycle busy=0 and duty shows the final value.
REQ-023 Breathe mode: a step reaching hi_duty SHALL switch UP to DOWN, and a step reaching lo_duty SHALL switch DOWN to UP. The next step follows a full period; done is never asserted.
REQ-024 stop=1 SHALL force IDLE on the next edge, freeze duty at its current value, keep done low, and clear the timer. If stop and start are both high in IDLE, start is ignored.
REQ-025 start while busy SHALL be ignored; latched parameters SHALL NOT change mid-operation.
REQ-026 duty SHALL change only on step edges or reset; all outputs are registered.

Reset
REQ-027 A synchronous reset SHALL set state=IDLE, duty=0, busy=0, done=0, timer=0 and clear all latched parameters.
REQ-028 A reset asserted mid-fade SHALL override stop and start; outputs SHALL take their reset values on the next edge.

Verification (R=10)
REQ-029 Basic fade: duty=0; start with breathe=0, hi=100, step=10, period=4 -> duty rises 10, 20, ... 100, one step every 5 cycles (first step at cycle 5). done pulses once, with busy=0, exactly 50 cycles after start.
REQ-030 Upper saturation: duty=1000; start with hi=2000, step=100, period=0 -> duty becomes 1024 in one step, then done pulses; no wrap-around.
REQ-031 Lower saturation: duty=30; start with hi=0, step=50 -> duty becomes 0 in one step, then done; with step=0, duty decreases by 1 per step.
REQ-032 Breathe: duty=0; start with breathe=1, lo=10, hi=40, step=10, period=0 -> duty 10, 20, 30, 40, 30, 20, 10, 20, ... with done=0. Asserting stop at duty=30 -> busy=0 on the next cycle and duty holds at 30.
REQ-033 Equal target and ignored requests: start with hi equal to the current duty -> done pulses the next cycle and duty is unchanged. A start issued mid-fade with new values -> ignored. start and stop together in IDLE -> no action.
REQ-034 Reset mid-ramp: assert reset during a breathe -> duty=0, busy=0, done=0 after one edge; a subsequent start works normally.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// PWM duty fader: ramps a registered duty word toward a target in fixed steps,
// either as a one-shot fade or as a continuous lo/hi breathe oscillation.
module pwm_fade_ctrl #(
    parameter int unsigned R = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        breathe,
    input  logic [R:0]  lo_duty,
    input  logic [R:0]  hi_duty,
    input  logic [R:0]  step,
    input  logic [31:0] step_period,
    output logic [R:0]  duty,
    output logic        busy,
    output logic        done
);

    localparam logic [R:0] Full = {1'b1, {R{1'b0}}};

    typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

    state_e      state_q, state_d;
    logic [R:0]  duty_q, duty_d;
    logic [R:0]  lo_q, lo_d, hi_q, hi_d, step_q, step_d;
    logic [31:0] period_q, period_d, timer_q, timer_d;
    logic        breathe_q, breathe_d;
    logic        done_q, done_d;
    logic        busy_q;

    // Clamped views of the request, used only when latching at start.
    logic [R:0] lo_c, hi_c, step_c;
    logic       mode_c;
    assign lo_c   = (lo_duty > Full) ? Full : lo_duty;
    assign hi_c   = (hi_duty > Full) ? Full : hi_duty;
    assign step_c = (step == '0) ? {{R{1'b0}}, 1'b1} : step;
    assign mode_c = breathe && (lo_c < hi_c);

    // Saturating step results, computed one bit wider so nothing wraps.
    logic [R:0]   floor_v, up_val, dn_val;
    logic [R+1:0] up_sum, dn_lim;
    logic         step_now;
    assign floor_v  = breathe_q ? lo_q : hi_q;
    assign up_sum   = {1'b0, duty_q} + {1'b0, step_q};
    assign up_val   = (up_sum >= {1'b0, hi_q}) ? hi_q : up_sum[R:0];
    assign dn_lim   = {1'b0, floor_v} + {1'b0, step_q};
    assign dn_val   = ({1'b0, duty_q} >= dn_lim) ? (duty_q - step_q) : floor_v;
    assign step_now = (timer_q == period_q);

    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        step_d    = step_q;
        period_d  = period_q;
        breathe_d = breathe_q;
        timer_d   = timer_q;
        done_d    = 1'b0;
        if (stop) begin
            state_d = StIdle;
            timer_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        lo_d      = lo_c;
                        hi_d      = hi_c;
                        step_d    = step_c;
                        period_d  = step_period;
                        breathe_d = mode_c;
                        timer_d   = '0;
                        if (duty_q < hi_c)                 state_d = StUp;
                        else if (mode_c || duty_q > hi_c)  state_d = StDown;
                        else                               done_d  = 1'b1;
                    end
                end
                StUp: begin
                    if (step_now) begin
                        timer_d = '0;
                        duty_d  = up_val;
                        if (up_val == hi_q) begin
                            state_d = breathe_q ? StDown : StIdle;
                            done_d  = !breathe_q;
                        end
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                StDown: begin
                    if (step_now) begin
                        timer_d = '0;
                        duty_d  = dn_val;
                        if (dn_val == floor_v) begin
                            state_d = breathe_q ? StUp : StIdle;
                            done_d  = !breathe_q;
                        end
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            duty_q    <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            step_q    <= '0;
            period_q  <= '0;
            breathe_q <= 1'b0;
            timer_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            step_q    <= step_d;
            period_q  <= period_d;
            breathe_q <= breathe_d;
            timer_q   <= timer_d;
            done_q    <= done_d;
            busy_q    <= (state_d != StIdle);
        end
    end

    assign duty = duty_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: directed scenarios plus random traffic, every cycle
// compared against a cycle-count based fade model.
module tb_pwm_fade_ctrl;

    localparam int R    = 10;
    localparam int FULL = 1 << R;

    logic        clk = 1'b0;
    logic        reset, start, stop, breathe;
    logic [R:0]  lo_duty, hi_duty, step, duty;
    logic [31:0] step_period;
    logic        busy, done;

    always #5 clk = ~clk;

    pwm_fade_ctrl #(.R(R)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .breathe    (breathe),
        .lo_duty    (lo_duty),
        .hi_duty    (hi_duty),
        .step       (step),
        .step_period(step_period),
        .duty       (duty),
        .busy       (busy),
        .done       (done)
    );

    int ncmp  = 0;
    int nfail = 0;

    // Model: a fade is "active" with a direction; a step lands every per+1 cycles.
    int m_duty = 0, m_active = 0, m_done = 0, m_dir = 0, m_cnt = 0;
    int m_lo = 0, m_hi = 0, m_step = 1, m_per = 0, m_br = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int lowb;
        m_done = 0;
        if (reset) begin
            m_duty = 0; m_active = 0; m_cnt = 0;
        end else if (stop) begin
            m_active = 0; m_cnt = 0;
        end else if (!m_active && start) begin
            m_lo   = (int'(lo_duty) > FULL) ? FULL : int'(lo_duty);
            m_hi   = (int'(hi_duty) > FULL) ? FULL : int'(hi_duty);
            m_step = (step == 0) ? 1 : int'(step);
            m_per  = int'(step_period);
            m_br   = (breathe && m_lo < m_hi) ? 1 : 0;
            m_cnt  = 0;
            if (!m_br && m_duty == m_hi) m_done = 1;
            else begin
                m_active = 1;
                m_dir    = (m_duty < m_hi) ? 1 : -1;
            end
        end else if (m_active) begin
            m_cnt++;
            if (m_cnt == m_per + 1) begin
                m_cnt = 0;
                if (m_dir > 0) begin
                    m_duty = (m_duty + m_step > m_hi) ? m_hi : m_duty + m_step;
                    if (m_duty == m_hi) begin
                        if (m_br) m_dir = -1;
                        else begin m_active = 0; m_done = 1; end
                    end
                end else begin
                    lowb   = m_br ? m_lo : m_hi;
                    m_duty = (m_duty - m_step < lowb) ? lowb : m_duty - m_step;
                    if (m_duty == lowb) begin
                        if (m_br) m_dir = 1;
                        else begin m_active = 0; m_done = 1; end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("duty", 32'(duty), m_duty);
        chk("busy", 32'(busy), m_active);
        chk("done", 32'(done), m_done);
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start(input int br, input int lo, input int hi, input int st,
                            input int per);
        breathe     = br[0];
        lo_duty     = lo[R:0];
        hi_duty     = hi[R:0];
        step        = st[R:0];
        step_period = per;
        start       = 1'b1;
        tick();
    endtask

    int done_at;
    int done_cnt;

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; breathe = 1'b0;
        lo_duty = '0; hi_duty = '0; step = '0; step_period = '0;
        tick();
        chk("reset_duty", 32'(duty), 0);
        chk("reset_busy", 32'(busy), 0);

        // Basic fade 0 -> 100, step 10 every 5 cycles, done at cycle 50.
        do_start(0, 0, 100, 10, 4);
        done_at = -1; done_cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
        chk("basic_done_cycle", done_at, 50);
        chk("basic_done_count", done_cnt, 1);
        chk("basic_final", 32'(duty), 100);

        // Upper saturation: 1000 + 100 clamps to 1024.
        do_start(0, 0, 1000, 900, 0);
        tick();
        do_start(0, 0, 2000, 100, 0);
        tick();
        chk("upper_sat", 32'(duty), 1024);
        run(2);

        // Lower saturation and step=0 treated as 1.
        do_start(0, 0, 30, 994, 0);
        tick();
        chk("down_to_30", 32'(duty), 30);
        do_start(0, 0, 0, 50, 0);
        tick();
        chk("lower_sat", 32'(duty), 0);
        do_start(0, 0, 3, 3, 0);
        tick();
        do_start(0, 0, 0, 0, 0);
        tick();
        chk("step0_first", 32'(duty), 2);
        run(3);
        chk("step0_final", 32'(duty), 0);

        // Breathe 10..40, stop when duty reaches 30 on the way down.
        do_start(1, 10, 40, 10, 0);
        run(5);
        chk("breathe_at_30", 32'(duty), 30);
        stop = 1'b1;
        tick();
        chk("stop_busy", 32'(busy), 0);
        run(2);
        chk("stop_hold", 32'(duty), 30);

        // Equal target: done next cycle, duty unchanged.
        do_start(0, 0, 30, 5, 0);
        chk("equal_done", 32'(done), 1);
        chk("equal_duty", 32'(duty), 30);

        // Start mid-fade ignored.
        do_start(0, 0, 100, 10, 3);
        run(5);
        hi_duty = 11'd0; step = 11'd500; start = 1'b1;
        tick();
        run(40);
        chk("midfade_ignored", 32'(duty), 100);

        // Start with stop in IDLE: nothing happens.
        hi_duty = 11'd500; start = 1'b1; stop = 1'b1;
        tick();
        run(3);
        chk("start_stop_idle", 32'(duty), 100);

        // Reset mid-breathe, then a normal fade.
        do_start(1, 0, 200, 20, 1);
        run(10);
        reset = 1'b1; stop = 1'b1; start = 1'b1;
        tick();
        chk("reset_mid_duty", 32'(duty), 0);
        chk("reset_mid_busy", 32'(busy), 0);
        do_start(0, 0, 50, 25, 0);
        run(3);
        chk("after_reset_fade", 32'(duty), 50);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            breathe     = ($urandom_range(0, 1) == 1);
            lo_duty     = 11'($urandom_range(0, 1100));
            hi_duty     = 11'($urandom_range(0, 1100));
            step        = 11'($urandom_range(0, 300));
            step_period = $urandom_range(0, 3);
            start       = ($urandom_range(0, 7) == 0);
            stop        = ($urandom_range(0, 40) == 0);
            reset       = ($urandom_range(0, 300) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
